// File: rtl/guess_fsm_n.sv
// Parametrised light-chasing guessing game: a single lit position steps across an
// N-wide display and the player must press the matching button before it moves on.
module guess_fsm_n #(
    parameter int N           = 4,
    parameter int STEP_CYCLES = 1,
    parameter int LIVES       = 3,
    parameter int SCORE_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic [N-1:0]                 b,
    output logic [N-1:0]                 y,
    output logic                         win,
    output logic                         lose,
    output logic                         game_over,
    output logic [SCORE_W-1:0]           score,
    output logic [$clog2(LIVES+1)-1:0]   lives
);

    localparam int PW = $clog2(N);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int LW = $clog2(LIVES + 1);

    localparam logic [1:0] PLAY = 2'd0;
    localparam logic [1:0] WIN  = 2'd1;
    localparam logic [1:0] LOSE = 2'd2;
    localparam logic [1:0] OVER = 2'd3;

    localparam logic [PW-1:0]      POS_LAST   = PW'(N - 1);
    localparam logic [PW-1:0]      POS_ONE    = PW'(1);
    localparam logic [SW-1:0]      STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0]      STEP_ONE   = SW'(1);
    localparam logic [LW-1:0]      LIVES_INIT = LW'(LIVES);
    localparam logic [LW-1:0]      LIFE_ONE   = LW'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    logic [1:0]         state, state_nxt;
    logic [PW-1:0]      pos, pos_nxt, adv_pos;
    logic               dir_down, dir_down_nxt, adv_down;
    logic [SW-1:0]      step, step_nxt;
    logic [SCORE_W-1:0] score_q, score_nxt;
    logic [LW-1:0]      lives_q, lives_nxt;

    logic guess;
    logic correct;

    // Position the display moves to on an advance, given the sampled mode and
    // current direction. Rotate always travels upward.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        adv_pos  = pos;
        adv_down = 1'b0;
        if (!mode) begin
            adv_pos  = (pos == POS_LAST) ? '0 : pos + POS_ONE;
            adv_down = 1'b0;
        end else if (!dir_down) begin
            if (pos == POS_LAST) begin
                adv_pos  = pos - POS_ONE;
                adv_down = 1'b1;
            end else begin
                adv_pos  = pos + POS_ONE;
                adv_down = 1'b0;
            end
        end else begin
            if (pos == '0) begin
                adv_pos  = POS_ONE;
                adv_down = 1'b0;
            end else begin
                adv_pos  = pos - POS_ONE;
                adv_down = 1'b1;
            end
        end
    end

    // Moore decode: outputs depend only on registered state and position.
    always_comb begin
        y         = '0;
        win       = 1'b0;
        lose      = 1'b0;
        game_over = 1'b0;
        case (state)
            PLAY:    y[pos] = 1'b1;
            WIN: begin
                y   = '1;
                win = 1'b1;
            end
            LOSE:    lose = 1'b1;
            default: begin
                lose      = 1'b1;
                game_over = 1'b1;
            end
        endcase
    end

    assign score   = score_q;
    assign lives   = lives_q;
    assign guess   = (b != '0);
    assign correct = (b == y);

    always_comb begin
        state_nxt    = state;
        pos_nxt      = pos;
        dir_down_nxt = dir_down;
        step_nxt     = step;
        score_nxt    = score_q;
        lives_nxt    = lives_q;
        case (state)
            PLAY: begin
                if (!guess) begin
                    if (step == STEP_LAST) begin
                        step_nxt     = '0;
                        pos_nxt      = adv_pos;
                        dir_down_nxt = adv_down;
                    end else begin
                        step_nxt = step + STEP_ONE;
                    end
                end else if (correct) begin
                    state_nxt = WIN;
                    if (score_q != SCORE_MAX) score_nxt = score_q + SCORE_ONE;
                end else begin
                    // A multi-bit press containing the lit bit still lands here.
                    lives_nxt = lives_q - LIFE_ONE;
                    state_nxt = (lives_q == LIFE_ONE) ? OVER : LOSE;
                end
            end
            WIN, LOSE: begin
                if (!guess) begin
                    state_nxt    = PLAY;
                    pos_nxt      = '0;
                    dir_down_nxt = 1'b0;
                    step_nxt     = '0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: reset is sampled on the clock edge like any other input, so it
    // lives inside the clocked block rather than in its sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= PLAY;
            pos      <= '0;
            dir_down <= 1'b0;
            step     <= '0;
            score_q  <= '0;
            lives_q  <= LIVES_INIT;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state    <= state_nxt;
            pos      <= pos_nxt;
            dir_down <= dir_down_nxt;
            step     <= step_nxt;
            score_q  <= score_nxt;
            lives_q  <= lives_nxt;
        end
    end

endmodule
